// File: rtl/pipe_valid_ctrl.sv
// Invalidation-countdown consumer: turns pending invalidation counts into pipeline
// bubbles, tracks per-stage valid bits, gates write enables and counts bubbles.
module pipe_valid_ctrl #(
  parameter int STAGES  = 5,
  parameter int CNT_W   = 3,
  parameter int MAX_CNT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  inv_cnt,
  input  logic              issue_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  cnt_nex,
  output logic [STAGES-1:0] stage_valid,
  output logic              mem_we_en,
  output logic              rf_we_en,
  output logic [PERF_W-1:0] bubble_cnt,
  output logic              cnt_err
);

  localparam logic [CNT_W-1:0] MAX_CNT_V = CNT_W'(MAX_CNT);

  logic [STAGES-1:0] stage_valid_q, stage_valid_d;
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic              cnt_err_q, cnt_err_d;
  logic              ins;
  logic              bubble;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    sat_inc = (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    ins    = issue_valid && (inv_cnt == '0) && !flush;
    bubble = issue_valid && (inv_cnt != '0) && !stall && !flush;

    // Countdown holds while stalled so the bubble is not consumed by a frozen pipe.
    if (stall)
      cnt_nex = inv_cnt;
    else if (inv_cnt != '0)
      cnt_nex = inv_cnt - CNT_W'(1);
    else
      cnt_nex = '0;

    stage_valid_d = stage_valid_q;
    if (!stall) begin
      stage_valid_d = {stage_valid_q[STAGES-2:0], ins};
      if (flush)
        stage_valid_d[STAGES-2:0] = '0;
    end else if (flush) begin
      // MEM and WB are frozen by the stall; only the younger stages are killed.
      stage_valid_d[STAGES-3:0] = '0;
    end

    bubble_cnt_d = bubble ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
    cnt_err_d    = cnt_err_q || (inv_cnt > MAX_CNT_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= '0;
      bubble_cnt_q  <= '0;
      cnt_err_q     <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      bubble_cnt_q  <= bubble_cnt_d;
      cnt_err_q     <= cnt_err_d;
    end
  end

  assign stage_valid = stage_valid_q;
  assign mem_we_en   = stage_valid_q[STAGES-2];
  assign rf_we_en    = stage_valid_q[STAGES-1];
  assign bubble_cnt  = bubble_cnt_q;
  assign cnt_err     = cnt_err_q;

endmodule

// File: tb/tb_pipe_valid_ctrl.sv
// Directed bench for pipe_valid_ctrl (STAGES=5, CNT_W=3, MAX_CNT=4, PERF_W=4 build).
module tb_pipe_valid_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] inv_cnt;
  logic       issue_valid;
  logic       stall;
  logic       flush;
  logic [2:0] cnt_nex;
  logic [4:0] stage_valid;
  logic       mem_we_en;
  logic       rf_we_en;
  logic [3:0] bubble_cnt;
  logic       cnt_err;

  int errors = 0;
  int checks = 0;

  pipe_valid_ctrl #(.STAGES(5), .CNT_W(3), .MAX_CNT(4), .PERF_W(4)) dut (
    .clk(clk), .reset(reset), .inv_cnt(inv_cnt), .issue_valid(issue_valid),
    .stall(stall), .flush(flush), .cnt_nex(cnt_nex), .stage_valid(stage_valid),
    .mem_we_en(mem_we_en), .rf_we_en(rf_we_en), .bubble_cnt(bubble_cnt),
    .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; inv_cnt = 3'd0; issue_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_sv", 32'(stage_valid), 32'h0);
    chk("rst_bub", 32'(bubble_cnt), 32'h0);
    chk("rst_err", 32'(cnt_err), 32'h0);
    chk("rst_mem", 32'(mem_we_en), 32'h0);
    chk("rst_rf", 32'(rf_we_en), 32'h0);
    inv_cnt = 3'd3; #1;
    chk("rst_cnt_nex", 32'(cnt_nex), 32'h2);

    // Fill the pipe
    reset = 1'b0; inv_cnt = 3'd0; issue_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      #1;
      chk("fill_cnt_nex", 32'(cnt_nex), 32'h0);
      step();
      chk("fill_sv", 32'(stage_valid), (i >= 5) ? 32'h1f : ((32'h1 << i) - 1));
      chk("fill_rf", 32'(rf_we_en), (i >= 5) ? 32'h1 : 32'h0);
      chk("fill_mem", 32'(mem_we_en), (i >= 4) ? 32'h1 : 32'h0);
    end

    // Countdown 3,2,1,0
    inv_cnt = 3'd3; #1; chk("cd3_nex", 32'(cnt_nex), 32'h2);
    step(); chk("cd3_sv", 32'(stage_valid), 32'h1e); chk("cd3_bub", 32'(bubble_cnt), 32'h1);
    inv_cnt = 3'd2; #1; chk("cd2_nex", 32'(cnt_nex), 32'h1);
    step(); chk("cd2_sv", 32'(stage_valid), 32'h1c); chk("cd2_bub", 32'(bubble_cnt), 32'h2);
    inv_cnt = 3'd1; #1; chk("cd1_nex", 32'(cnt_nex), 32'h0);
    step(); chk("cd1_sv", 32'(stage_valid), 32'h18); chk("cd1_bub", 32'(bubble_cnt), 32'h3);
    inv_cnt = 3'd0; #1; chk("cd0_nex", 32'(cnt_nex), 32'h0);
    step(); chk("cd0_sv", 32'(stage_valid), 32'h11); chk("cd0_bub", 32'(bubble_cnt), 32'h3);

    // Stall holds count, valids and bubble counter; MAX_CNT itself is legal
    inv_cnt = 3'd4; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; chk("stall_nex", 32'(cnt_nex), 32'h4);
      step();
      chk("stall_sv", 32'(stage_valid), 32'h11);
      chk("stall_bub", 32'(bubble_cnt), 32'h3);
    end
    stall = 1'b0; #1; chk("rel_nex", 32'(cnt_nex), 32'h3);
    step();
    chk("rel_sv", 32'(stage_valid), 32'h02);
    chk("rel_bub", 32'(bubble_cnt), 32'h4);
    chk("max_no_err", 32'(cnt_err), 32'h0);

    // Flush without stall: MEM bit retires to WB
    inv_cnt = 3'd0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_flush_sv", 32'(stage_valid), 32'h1f);
    flush = 1'b1;
    step();
    chk("flush_sv", 32'(stage_valid), 32'h10);
    chk("flush_mem", 32'(mem_we_en), 32'h0);
    chk("flush_rf", 32'(rf_we_en), 32'h1);
    chk("flush_bub", 32'(bubble_cnt), 32'h4);
    flush = 1'b0;

    // Flush during stall: MEM/WB hold, younger stages cleared
    for (int i = 0; i < 5; i++) step();
    chk("pre_sflush_sv", 32'(stage_valid), 32'h1f);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("sflush_sv", 32'(stage_valid), 32'h18);
    stall = 1'b0; flush = 1'b0;

    // Out-of-range count: sticky error, still decrements
    inv_cnt = 3'd6; #1; chk("err_nex", 32'(cnt_nex), 32'h5);
    step();
    chk("err_set", 32'(cnt_err), 32'h1);
    chk("err_sv", 32'(stage_valid), 32'h10);
    chk("err_bub", 32'(bubble_cnt), 32'h5);
    inv_cnt = 3'd0; issue_valid = 1'b0;
    step(); step();
    chk("err_sticky", 32'(cnt_err), 32'h1);
    chk("idle_sv", 32'(stage_valid), 32'h0);

    // Saturation of the 4-bit bubble counter
    issue_valid = 1'b1; inv_cnt = 3'd2;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 9)  chk("sat_14", 32'(bubble_cnt), 32'he);
      if (i == 10) chk("sat_15", 32'(bubble_cnt), 32'hf);
    end
    chk("sat_hold", 32'(bubble_cnt), 32'hf);
    chk("sat_sv", 32'(stage_valid), 32'h0);

    // Reset mid-stream
    inv_cnt = 3'd0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_rf", 32'(rf_we_en), 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_sv", 32'(stage_valid), 32'h0);
    chk("mid_rst_bub", 32'(bubble_cnt), 32'h0);
    chk("mid_rst_err", 32'(cnt_err), 32'h0);
    chk("mid_rst_rf", 32'(rf_we_en), 32'h0);
    chk("mid_rst_mem", 32'(mem_we_en), 32'h0);
    reset = 1'b0;
    step();
    chk("post_rst_sv", 32'(stage_valid), 32'h1);
    chk("post_rst_rf", 32'(rf_we_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_valid_ctrl.md
Name: pipe_valid_ctrl

Overview:
Consumer side of the core's register-invalidation countdown. It takes the current invalidation count each cycle and returns the next-count value to the counter. It converts non-zero counts into pipeline bubbles by clearing valid bits in a per-stage valid shift register. It also gates register-file and data-memory write enables, handles stall and flush, and keeps a saturating bubble counter for performance monitoring.

Parameters:
STAGES, 5, number of pipeline stages tracked (index 0 = IF ... STAGES-1 = WB); legal range 3..8
CNT_W, 3, width of invalidation count in/out
MAX_CNT, 4, largest legal inv_cnt value; larger values set cnt_err
PERF_W, 16, width of bubble performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inv_cnt  in  CNT_W  current invalidation count from the counter; 0 = no pending invalidation
issue_valid  in  1  fetch presents an instruction this cycle
stall  in  1  freeze the pipeline (memory wait)
flush  in  1  kill all in-flight instructions in stages 0..STAGES-3
cnt_nex  out  CNT_W  next-count value returned to the counter (combinational)
stage_valid  out  STAGES  per-stage valid bits (registered)
mem_we_en  out  1  data-memory write permitted = stage_valid[STAGES-2]
rf_we_en  out  1  register-file write permitted = stage_valid[STAGES-1]
bubble_cnt  out  PERF_W  saturating count of inserted bubbles
cnt_err  out  1  sticky: inv_cnt > MAX_CNT was seen

Behaviour:
- Reset, checked before all other conditions:
  - stage_valid = 0, bubble_cnt = 0, cnt_err = 0.
  - cnt_nex is combinational from inputs and is not affected by reset.
- Admission: ins = issue_valid && (inv_cnt == 0) && !flush.
- Bubble condition: issue_valid && inv_cnt != 0 && !stall && !flush.
- cnt_nex (combinational):
  - stall = 1: cnt_nex = inv_cnt (hold).
  - stall = 0 and inv_cnt != 0: cnt_nex = inv_cnt - 1.
  - stall = 0 and inv_cnt == 0: cnt_nex = 0.
  - cnt_nex never underflows.
  - cnt_nex = 0 signals the counter to reload from the decode class.
- stage_valid update, no stall:
  - stage_valid <= {stage_valid[STAGES-2:0], ins}.
  - flush = 1: after the shift, bits [STAGES-2:0] are forced to 0. stage_valid[STAGES-1] keeps the shifted-in value from stage STAGES-2, so older instructions in MEM retire to WB.
- stall = 1 and flush = 0: stage_valid holds entirely; nothing is admitted.
- stall = 1 and flush = 1: flush wins for bits [STAGES-3:0], which are cleared. Bits STAGES-2 and STAGES-1 hold.
- Latency:
  - An instruction admitted in cycle t has stage_valid[k] = 1 in cycle t+1+k, absent stalls.
  - rf_we_en asserts STAGES cycles after admission.
- Bubble accounting: bubble_cnt += 1 on each cycle meeting the bubble condition; saturates at all-ones.
- cnt_err:
  - Set on any cycle with inv_cnt > MAX_CNT.
  - Stays set until reset.
  - cnt_nex still decrements normally in that case.
- Enables:
  - mem_we_en and rf_we_en are pure functions of the registered stage_valid; no combinational path from inputs.
- Reset mid-operation: all in-flight valids are lost in the next cycle. No write enable asserts in the cycle after reset.

Test Plan:
- Reset, then issue_valid=1, inv_cnt=0 for 6 cycles -> stage_valid fills 00001, 00011, ... 11111; rf_we_en first high 5 cycles after the first admission; cnt_nex=0 throughout.
- inv_cnt sequence 3,2,1,0 with issue_valid=1, stall=0 -> cnt_nex 2,1,0,0; three zero bits shifted into stage_valid; bubble_cnt=3.
- inv_cnt=4 with stall=1 for 2 cycles, then released -> cnt_nex=4,4 then 3; stage_valid unchanged during stall; bubble_cnt increments only after release.
- stage_valid=11111, flush=1, stall=0, issue_valid=1 -> next stage_valid=10000 (shifted MEM bit retires to WB); mem_we_en=0 and rf_we_en=1 next cycle.
- inv_cnt=6 for 1 cycle -> cnt_err=1 and remains 1 until reset; cnt_nex=5.
- Force bubble_cnt to near max (PERF_W=4 build), apply 20 bubble cycles -> saturates at 15; reset mid-stream clears stage_valid and bubble_cnt next cycle.
